instr_fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 39 +++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction path: opcodes, CU handshake
// codes, instruction field positions and fetch-unit FSM encodings.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_LT   = 4'b1010;
    localparam logic [3:0] OP_EQ   = 4'b1011;
    localparam logic [3:0] OP_MVI  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] CU_IDLE = 2'b00;
    localparam logic [1:0] CU_DONE = 2'b11;

    // Instruction word layout: [15:12] opcode, [11:6] dest, [5:0] src
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 6;
    localparam int SRC_MSB = 5;
    localparam int SRC_LSB = 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_CLEAR  = 3'd5;
    localparam logic [2:0] S_HALTED = 3'd6;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/sequencing unit: reads ROM words, splits them into
// opcode/dest/src for the CU, holds each until the CU reports done (or the
// instruction times out), clears the CU with a NOP and advances the pc.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ROM_LATENCY = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_enable,
    input  logic [15:0]       rom_data,
    input  logic [1:0]        cu_state,
    output logic [3:0]        opcode,
    output logic [5:0]        dest,
    output logic [5:0]        src,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [15:0]       instr_count
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam int LAT_W = $clog2(ROM_LATENCY + 1);

    logic [2:0]       state;
    logic [15:0]      ir;
    logic [TMR_W-1:0] timer;
    logic [LAT_W-1:0] lat_cnt;
    logic [3:0]       ir_op;

    assign ir_op = ir[OPC_MSB:OPC_LSB];

    // Status and ROM strobe are pure decodes of the state and pc
    assign rom_address     = pc;
    assign rom_read_enable = (state == S_FETCH);
    assign busy            = (state != S_IDLE) && (state != S_HALTED);
    assign halted          = (state == S_HALTED);

    // Sequencer FSM with inline ROM-latency counter and execution timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            ir          <= '0;
            opcode      <= OP_NOP;
            dest        <= '0;
            src         <= '0;
            timer       <= '0;
            lat_cnt     <= '0;
            timeout_err <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    lat_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (lat_cnt == LAT_W'(ROM_LATENCY - 1)) begin
                        ir    <= rom_data;
                        state <= S_DECODE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (ir_op == OP_HALT) begin
                        state <= S_HALTED;
                    end else if (ir_op == OP_NOP) begin
                        pc          <= pc + 1'b1;
                        instr_count <= bump_count(instr_count);
                        state       <= S_FETCH;
                    end else if (cu_state == CU_IDLE) begin
                        opcode <= ir_op;
                        dest   <= ir[DST_MSB:DST_LSB];
                        src    <= ir[SRC_MSB:SRC_LSB];
                        timer  <= '0;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Done takes priority over a simultaneous timeout
                    if (cu_state == CU_DONE) begin
                        opcode <= OP_NOP;
                        dest   <= '0;
                        src    <= '0;
                        state  <= S_CLEAR;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        opcode      <= OP_NOP;
                        dest        <= '0;
                        src         <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_CLEAR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cu_state == CU_IDLE) begin
                        pc          <= pc + 1'b1;
                        instr_count <= bump_count(instr_count);
                        state       <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    opcode <= OP_NOP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    function automatic logic [15:0] bump_count(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endmodule
